// File: rtl/vme_pkg.sv
// Shared types and encodings for the VME master transfer engine.
package vme_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDRESS,
    ST_DATA,
    ST_TERMINATE
  } vme_state_e;

  localparam logic ACTIVE   = 1'b0;
  localparam logic INACTIVE = 1'b1;
  localparam logic DIR_OUT  = 1'b0;
  localparam logic DIR_IN   = 1'b1;

  localparam logic [1:0] SPACE_A16  = 2'b00;
  localparam logic [1:0] SPACE_A24  = 2'b01;
  localparam logic [1:0] SPACE_A32  = 2'b10;
  localparam logic [1:0] SPACE_RSVD = 2'b11;

  localparam logic [5:0] AM_NONE = 6'h3F;

  typedef struct packed {
    logic       addr_oe;
    logic       vme_as;
    logic       vme_lword;
    logic       vme_write;
    logic [1:0] vme_ds;
    logic [5:0] am;
    logic [1:0] cpu_dsack;
    logic       cpu_berr;
    logic       cross_oe;
    logic       cross_dir;
    logic       low_oe;
    logic       low_dir;
    logic       high_oe;
    logic       high_dir;
  } vme_drive_t;

  localparam vme_drive_t DRIVE_IDLE = '{
    addr_oe:   INACTIVE,
    vme_as:    INACTIVE,
    vme_lword: INACTIVE,
    vme_write: INACTIVE,
    vme_ds:    2'b11,
    am:        AM_NONE,
    cpu_dsack: 2'b11,
    cpu_berr:  INACTIVE,
    cross_oe:  INACTIVE,
    cross_dir: DIR_OUT,
    low_oe:    INACTIVE,
    low_dir:   DIR_OUT,
    high_oe:   INACTIVE,
    high_dir:  DIR_OUT
  };

  function automatic logic fc_valid(input logic [2:0] fc);
    return (fc == 3'b001) || (fc == 3'b010) || (fc == 3'b101) || (fc == 3'b110);
  endfunction

  // For the four valid FCs the low AM bits equal the FC itself in A24/A32.
  function automatic logic [5:0] vme_am(input logic [1:0] space, input logic [2:0] fc);
    logic [5:0] am;
    am = AM_NONE;
    if (fc_valid(fc)) begin
      case (space)
        SPACE_A16: am = {3'b101, fc[2], 2'b01};
        SPACE_A24: am = {3'b111, fc};
        SPACE_A32: am = {3'b001, fc};
        default:   am = AM_NONE;
      endcase
    end
    return am;
  endfunction

endpackage

// File: rtl/vme_cycle_timer.sv
// Loadable saturating down-counter shared by the setup and timeout phases.
module vme_cycle_timer #(
  parameter int unsigned MAX_COUNT = 1023
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             load_i,
  input  logic [$clog2(MAX_COUNT + 1)-1:0] value_i,
  output logic                             expired_o
);

  localparam int unsigned WIDTH = $clog2(MAX_COUNT + 1);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= value_i;
    end else if (count_q != '0) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign expired_o = (count_q == '0);

endmodule

// File: rtl/vme_master_transfer.sv
// VME master data-transfer engine: one VME cycle per granted CPU cycle.
module vme_master_transfer
  import vme_pkg::*;
#(
  parameter int          DATA_WIDTH     = 16,
  parameter int unsigned SETUP_CYCLES   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       request_vme_sync,
  input  logic [1:0] request_space,
  input  logic       bus_acquired_sync,
  input  logic       cpu_as_sync,
  input  logic       cpu_ds_sync,
  input  logic       cpu_write,
  input  logic [1:0] cpu_siz,
  input  logic [1:0] cpu_address,
  input  logic [2:0] cpu_fc,
  output logic [1:0] cpu_dsack,
  output logic       cpu_berr,
  output logic       vme_as,
  output logic       vme_lword,
  output logic       vme_write,
  output logic [1:0] vme_ds,
  output logic [5:0] vme_address_mod,
  input  logic       vme_dtack_sync,
  input  logic       vme_berr_sync,
  output logic       addr_oe,
  output logic       d16_cross_oe,
  output logic       d16_cross_dir,
  output logic       d32_low_oe,
  output logic       d32_low_dir,
  output logic       d32_high_oe,
  output logic       d32_high_dir,
  output logic       status_led
);

  localparam int unsigned TMR_MAX = (TIMEOUT_CYCLES - 1 > SETUP_CYCLES) ?
                                    TIMEOUT_CYCLES - 1 : SETUP_CYCLES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] SETUP_LOAD   = TMR_W'(SETUP_CYCLES);
  localparam logic [TMR_W-1:0] TIMEOUT_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

  vme_state_e       state_q, state_d;
  vme_drive_t       drv_q, drv_d;
  logic             write_q, write_d;
  logic             d32_q, d32_d;
  logic [1:0]       ds_code_q, ds_code_d;
  logic             tmr_load, tmr_expired;
  logic [TMR_W-1:0] tmr_value;
  logic             start_ok, space_ok, req_d32, req_byte, go_data, bus_error;
  logic [1:0]       req_ds_code;

  // CPU AS is part of the qualifier so a stale decode cannot launch a cycle.
  assign start_ok = (request_vme_sync == ACTIVE) && (bus_acquired_sync == ACTIVE) &&
                    (cpu_as_sync == ACTIVE) && (vme_dtack_sync == INACTIVE) &&
                    (vme_berr_sync == INACTIVE);
  assign space_ok = (request_space != SPACE_RSVD) && fc_valid(cpu_fc);

  assign req_d32     = (DATA_WIDTH == 32) && (cpu_siz == 2'b00) && (cpu_address == 2'b00);
  assign req_byte    = (cpu_siz == 2'b01) || cpu_address[0];
  assign req_ds_code = (req_d32 || !req_byte) ? 2'b00 : (cpu_address[0] ? 2'b10 : 2'b01);

  assign go_data   = (state_q == ST_ADDRESS) && tmr_expired && (cpu_ds_sync == ACTIVE);
  assign tmr_load  = (state_q == ST_IDLE) || go_data;
  assign tmr_value = (state_q == ST_IDLE) ? SETUP_LOAD : TIMEOUT_LOAD;

  vme_cycle_timer #(
    .MAX_COUNT(TMR_MAX)
  ) u_timer (
    .clock    (clock),
    .reset    (reset),
    .load_i   (tmr_load),
    .value_i  (tmr_value),
    .expired_o(tmr_expired)
  );

  always_comb begin
    state_d   = state_q;
    drv_d     = drv_q;
    write_d   = write_q;
    d32_d     = d32_q;
    ds_code_d = ds_code_q;
    bus_error = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          if (!space_ok) begin
            drv_d.cpu_berr = ACTIVE;
            state_d        = ST_TERMINATE;
          end else begin
            write_d         = cpu_write;
            d32_d           = req_d32;
            ds_code_d       = req_ds_code;
            drv_d.addr_oe   = ACTIVE;
            drv_d.am        = vme_am(request_space, cpu_fc);
            drv_d.vme_lword = req_d32 ? ACTIVE : INACTIVE;
            drv_d.vme_write = cpu_write;
            state_d         = ST_ADDRESS;
          end
        end
      end
      ST_ADDRESS: begin
        drv_d.vme_as = ACTIVE;
        if (go_data) begin
          drv_d.vme_ds = ds_code_q;
          state_d      = ST_DATA;
          if (d32_q) begin
            drv_d.low_oe   = ACTIVE;
            drv_d.low_dir  = write_q ? DIR_IN : DIR_OUT;
            drv_d.high_oe  = ACTIVE;
            drv_d.high_dir = write_q ? DIR_IN : DIR_OUT;
          end else begin
            drv_d.cross_oe  = ACTIVE;
            drv_d.cross_dir = write_q ? DIR_IN : DIR_OUT;
          end
        end
      end
      ST_DATA: begin
        if (vme_berr_sync == ACTIVE) begin
          bus_error = 1'b1;
        end else if (vme_dtack_sync == ACTIVE) begin
          drv_d.cpu_dsack = d32_q ? 2'b00 : 2'b01;
          state_d         = ST_TERMINATE;
        end else if (tmr_expired || (request_vme_sync == INACTIVE)) begin
          bus_error = 1'b1;
        end
        if (bus_error) begin
          drv_d.cpu_berr = ACTIVE;
          drv_d.vme_as   = INACTIVE;
          drv_d.vme_ds   = 2'b11;
          state_d        = ST_TERMINATE;
        end
      end
      ST_TERMINATE: begin
        if ((cpu_ds_sync == INACTIVE) && (request_vme_sync == INACTIVE)) begin
          drv_d   = DRIVE_IDLE;
          state_d = ST_IDLE;
        end
      end
      default: begin
        drv_d   = DRIVE_IDLE;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      drv_q     <= DRIVE_IDLE;
      write_q   <= INACTIVE;
      d32_q     <= 1'b0;
      ds_code_q <= 2'b11;
    end else begin
      state_q   <= state_d;
      drv_q     <= drv_d;
      write_q   <= write_d;
      d32_q     <= d32_d;
      ds_code_q <= ds_code_d;
    end
  end

  assign cpu_dsack       = drv_q.cpu_dsack;
  assign cpu_berr        = drv_q.cpu_berr;
  assign vme_as          = drv_q.vme_as;
  assign vme_lword       = drv_q.vme_lword;
  assign vme_write       = drv_q.vme_write;
  assign vme_ds          = drv_q.vme_ds;
  assign vme_address_mod = drv_q.am;
  assign addr_oe         = drv_q.addr_oe;
  assign d16_cross_oe    = drv_q.cross_oe;
  assign d16_cross_dir   = drv_q.cross_dir;
  assign d32_low_oe      = drv_q.low_oe;
  assign d32_low_dir     = drv_q.low_dir;
  assign d32_high_oe     = drv_q.high_oe;
  assign d32_high_dir    = drv_q.high_dir;
  assign status_led      = (state_q == ST_ADDRESS) || (state_q == ST_DATA);

endmodule

// File: tb/tb_vme_master_transfer.sv
// Directed bench: a 32-bit/16-clock-timeout build plus a default 16-bit build on shared stimulus.
module tb_vme_master_transfer;

  logic       clock = 1'b0;
  logic       reset;
  logic       request_vme_sync, bus_acquired_sync, cpu_as_sync, cpu_ds_sync, cpu_write;
  logic [1:0] request_space, cpu_siz, cpu_address;
  logic [2:0] cpu_fc;
  logic       vme_dtack_sync, vme_berr_sync;

  logic [1:0] a_dsack, a_ds, b_dsack, b_ds;
  logic [5:0] a_am, b_am;
  logic       a_berr, a_as, a_lword, a_write, a_addr_oe, a_x_oe, a_x_dir;
  logic       a_lo_oe, a_lo_dir, a_hi_oe, a_hi_dir, a_led;
  logic       b_berr, b_as, b_lword, b_write, b_addr_oe, b_x_oe, b_x_dir;
  logic       b_lo_oe, b_lo_dir, b_hi_oe, b_hi_dir, b_led;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  vme_master_transfer #(
    .DATA_WIDTH(32), .SETUP_CYCLES(2), .TIMEOUT_CYCLES(16)
  ) dut32 (
    .clock(clock), .reset(reset), .request_vme_sync(request_vme_sync),
    .request_space(request_space), .bus_acquired_sync(bus_acquired_sync),
    .cpu_as_sync(cpu_as_sync), .cpu_ds_sync(cpu_ds_sync), .cpu_write(cpu_write),
    .cpu_siz(cpu_siz), .cpu_address(cpu_address), .cpu_fc(cpu_fc),
    .cpu_dsack(a_dsack), .cpu_berr(a_berr), .vme_as(a_as), .vme_lword(a_lword),
    .vme_write(a_write), .vme_ds(a_ds), .vme_address_mod(a_am),
    .vme_dtack_sync(vme_dtack_sync), .vme_berr_sync(vme_berr_sync),
    .addr_oe(a_addr_oe), .d16_cross_oe(a_x_oe), .d16_cross_dir(a_x_dir),
    .d32_low_oe(a_lo_oe), .d32_low_dir(a_lo_dir), .d32_high_oe(a_hi_oe),
    .d32_high_dir(a_hi_dir), .status_led(a_led)
  );

  vme_master_transfer #(
    .DATA_WIDTH(16), .SETUP_CYCLES(2), .TIMEOUT_CYCLES(1023)
  ) dut16 (
    .clock(clock), .reset(reset), .request_vme_sync(request_vme_sync),
    .request_space(request_space), .bus_acquired_sync(bus_acquired_sync),
    .cpu_as_sync(cpu_as_sync), .cpu_ds_sync(cpu_ds_sync), .cpu_write(cpu_write),
    .cpu_siz(cpu_siz), .cpu_address(cpu_address), .cpu_fc(cpu_fc),
    .cpu_dsack(b_dsack), .cpu_berr(b_berr), .vme_as(b_as), .vme_lword(b_lword),
    .vme_write(b_write), .vme_ds(b_ds), .vme_address_mod(b_am),
    .vme_dtack_sync(vme_dtack_sync), .vme_berr_sync(vme_berr_sync),
    .addr_oe(b_addr_oe), .d16_cross_oe(b_x_oe), .d16_cross_dir(b_x_dir),
    .d32_low_oe(b_lo_oe), .d32_low_dir(b_lo_dir), .d32_high_oe(b_hi_oe),
    .d32_high_dir(b_hi_dir), .status_led(b_led)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_req(input logic [1:0] space, input logic [2:0] fc, input logic [1:0] siz,
                           input logic [1:0] addr, input logic wr, input logic ds);
    request_space    = space;
    cpu_fc           = fc;
    cpu_siz          = siz;
    cpu_address      = addr;
    cpu_write        = wr;
    cpu_as_sync      = 1'b0;
    cpu_ds_sync      = ds;
    request_vme_sync = 1'b0;
  endtask

  task automatic release_all();
    request_vme_sync = 1'b1;
    cpu_as_sync      = 1'b1;
    cpu_ds_sync      = 1'b1;
    vme_dtack_sync   = 1'b1;
    vme_berr_sync    = 1'b1;
    repeat (3) tick();
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_as"}, a_as, 1'b1);
    check({tag, "_ds"}, a_ds, 2'b11);
    check({tag, "_am"}, a_am, 6'h3F);
    check({tag, "_addr_oe"}, a_addr_oe, 1'b1);
    check({tag, "_x_oe"}, a_x_oe, 1'b1);
    check({tag, "_lo_oe"}, a_lo_oe, 1'b1);
    check({tag, "_hi_oe"}, a_hi_oe, 1'b1);
    check({tag, "_lword"}, a_lword, 1'b1);
    check({tag, "_dsack"}, a_dsack, 2'b11);
    check({tag, "_berr"}, a_berr, 1'b1);
    check({tag, "_led"}, a_led, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    reset = 1'b1;
    bus_acquired_sync = 1'b1;
    request_vme_sync = 1'b1; cpu_as_sync = 1'b1; cpu_ds_sync = 1'b1; cpu_write = 1'b1;
    request_space = 2'b00; cpu_siz = 2'b00; cpu_address = 2'b00; cpu_fc = 3'b000;
    vme_dtack_sync = 1'b1; vme_berr_sync = 1'b1;
    repeat (2) tick();
    check_idle("reset");
    check("reset_write", a_write, 1'b1);
    check("reset_dirs", {a_x_dir, a_lo_dir, a_hi_dir}, 3'b000);
    check("reset16_ds", b_ds, 2'b11);
    reset = 1'b0;
    bus_acquired_sync = 1'b0;
    repeat (2) tick();

    // A24 supervisor-data word read at address 0, DTACK 5 clocks into DATA
    drive_req(2'b01, 3'b101, 2'b10, 2'b00, 1'b1, 1'b0);
    tick();
    check("t1_am", a_am, 6'h3D);
    check("t1_addr_oe", a_addr_oe, 1'b0);
    check("t1_as_early", a_as, 1'b1);
    check("t1_led", a_led, 1'b1);
    tick();
    check("t1_as", a_as, 1'b0);
    check("t1_ds_setup0", a_ds, 2'b11);
    tick();
    check("t1_ds_setup1", a_ds, 2'b11);
    tick();
    check("t1_ds", a_ds, 2'b00);
    check("t1_x_oe", a_x_oe, 1'b0);
    check("t1_x_dir", a_x_dir, 1'b1);
    check("t1_lo_oe", a_lo_oe, 1'b1);
    repeat (4) tick();
    check("t1_dsack_wait", a_dsack, 2'b11);
    vme_dtack_sync = 1'b0;
    tick();
    check("t1_dsack", a_dsack, 2'b01);
    check("t1_berr", a_berr, 1'b1);
    request_vme_sync = 1'b1; cpu_as_sync = 1'b1; cpu_ds_sync = 1'b1; vme_dtack_sync = 1'b1;
    tick();
    check_idle("t1_end");
    tick();

    // A32 supervisor-data long write at address 0
    drive_req(2'b10, 3'b101, 2'b00, 2'b00, 1'b0, 1'b0);
    tick();
    check("t2_am", a_am, 6'h0D);
    check("t2_lword", a_lword, 1'b0);
    check("t2_write", a_write, 1'b0);
    check("t2_lword16", b_lword, 1'b1);
    repeat (3) tick();
    check("t2_ds", a_ds, 2'b00);
    check("t2_lo", {a_lo_oe, a_lo_dir}, 2'b00);
    check("t2_hi", {a_hi_oe, a_hi_dir}, 2'b00);
    check("t2_x_oe", a_x_oe, 1'b1);
    check("t2_x16", {b_x_oe, b_x_dir}, 2'b00);
    vme_dtack_sync = 1'b0;
    tick();
    check("t2_dsack", a_dsack, 2'b00);
    check("t2_dsack16", b_dsack, 2'b01);
    release_all();

    // Same long transfer at address 2 degrades to a word
    drive_req(2'b10, 3'b101, 2'b00, 2'b10, 1'b0, 1'b0);
    tick();
    check("t2b_lword", a_lword, 1'b1);
    repeat (3) tick();
    check("t2b_x", {a_x_oe, a_x_dir}, 2'b00);
    check("t2b_lo_oe", a_lo_oe, 1'b1);
    check("t2b_ds", a_ds, 2'b00);
    vme_dtack_sync = 1'b0;
    tick();
    check("t2b_dsack", a_dsack, 2'b01);
    release_all();

    // A16 user byte write at odd address; stale DTACK blocks start, CPU DS late
    vme_dtack_sync = 1'b0;
    drive_req(2'b00, 3'b001, 2'b01, 2'b01, 1'b0, 1'b1);
    tick();
    check("t3_blocked_oe", a_addr_oe, 1'b1);
    check("t3_blocked_led", a_led, 1'b0);
    vme_dtack_sync = 1'b1;
    tick();
    check("t3_am", a_am, 6'h29);
    check("t3_addr_oe", a_addr_oe, 1'b0);
    repeat (3) tick();
    check("t3_ds_late", a_ds, 2'b11);
    cpu_ds_sync = 1'b0;
    tick();
    check("t3_ds", a_ds, 2'b10);
    check("t3_x_dir", a_x_dir, 1'b0);
    vme_dtack_sync = 1'b0;
    tick();
    check("t3_dsack", a_dsack, 2'b01);
    release_all();

    // No DTACK: timeout 16 clocks after DATA entry
    drive_req(2'b01, 3'b010, 2'b10, 2'b00, 1'b1, 1'b0);
    tick();
    check("t4_am", a_am, 6'h3A);
    repeat (3) tick();
    check("t4_ds_entry", a_ds, 2'b00);
    repeat (15) tick();
    check("t4_berr_pre", a_berr, 1'b1);
    check("t4_as_pre", a_as, 1'b0);
    tick();
    check("t4_berr", a_berr, 1'b0);
    check("t4_as", a_as, 1'b1);
    check("t4_ds", a_ds, 2'b11);
    check("t4_dsack", a_dsack, 2'b11);
    tick();
    check("t4_berr_hold", a_berr, 1'b0);
    release_all();
    check("t4_idle16", b_berr, 1'b1);

    // IACK function code and reserved space both error without strobes
    drive_req(2'b01, 3'b111, 2'b10, 2'b00, 1'b1, 1'b0);
    tick();
    check("t5_berr", a_berr, 1'b0);
    check("t5_addr_oe", a_addr_oe, 1'b1);
    check("t5_led", a_led, 1'b0);
    tick();
    check("t5_as", a_as, 1'b1);
    release_all();
    drive_req(2'b11, 3'b101, 2'b10, 2'b00, 1'b1, 1'b0);
    tick();
    check("t5r_berr", a_berr, 1'b0);
    tick();
    check("t5r_as", a_as, 1'b1);
    release_all();

    // BERR coincident with DTACK wins
    drive_req(2'b01, 3'b101, 2'b10, 2'b00, 1'b1, 1'b0);
    repeat (4) tick();
    vme_dtack_sync = 1'b0;
    vme_berr_sync  = 1'b0;
    tick();
    check("t6_berr", a_berr, 1'b0);
    check("t6_dsack", a_dsack, 2'b11);
    check("t6_as", a_as, 1'b1);
    release_all();

    // Reset mid-DATA, then a fresh cycle
    drive_req(2'b01, 3'b101, 2'b10, 2'b00, 1'b1, 1'b0);
    repeat (4) tick();
    check("t7_in_data", a_x_oe, 1'b0);
    reset = 1'b1;
    tick();
    check_idle("t7_rst");
    reset = 1'b0;
    release_all();
    drive_req(2'b01, 3'b110, 2'b10, 2'b00, 1'b1, 1'b0);
    tick();
    check("t7_am", a_am, 6'h3E);
    repeat (3) tick();
    check("t7_ds", a_ds, 2'b00);
    vme_dtack_sync = 1'b0;
    tick();
    check("t7_dsack", a_dsack, 2'b01);
    release_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vme_master_transfer.md
# vme_master_transfer

Parametrised VME master data-transfer engine sitting between the synchronised 68030 bus-request decode and the VME bus drivers. It runs one VME cycle per CPU cycle once the arbiter grants the bus, and supports:
- A16/A24/A32 address spaces;
- D8/D16 transfers, plus D32 when built 32 bits wide;
- a programmable address-to-strobe setup time;
- a bus-timeout watchdog that converts hung cycles into CPU bus errors.

## Interface
Parameters:
- DATA_WIDTH, 16: VME data path width; 16 or 32; 32 enables D32 transfers.
- SETUP_CYCLES, 2: clocks between vme_as assertion and vme_ds assertion; 1..15.
- TIMEOUT_CYCLES, 1023: clocks allowed in DATA before forced bus error; 1..65535.

Ports (control signals active-low unless noted; the `_sync` inputs come already synchronised):
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- request_vme_sync  in  1  CPU cycle decoded to VME.
- request_space  in  2  00 A16, 01 A24, 10 A32, 11 reserved.
- bus_acquired_sync  in  1  arbiter grant held.
- cpu_as_sync, cpu_ds_sync  in  1  CPU strobes.
- cpu_write  in  1  CPU R/W; 0 = write.
- cpu_siz  in  2  68030 SIZ.
- cpu_address  in  2  A1:A0.
- cpu_fc  in  3  function code.
- cpu_dsack  out  2  DSACK1:0.
- cpu_berr  out  1  bus error to CPU.
- vme_as, vme_lword, vme_write  out  1  VME strobes.
- vme_ds  out  2  DS1:DS0.
- vme_address_mod  out  6  AM code.
- vme_dtack_sync, vme_berr_sync  in  1  slave responses.
- addr_oe  out  1  address transceivers.
- d16_cross_oe, d16_cross_dir  out  1  CPU D31:16 ↔ VME D15:0.
- d32_low_oe, d32_low_dir  out  1  CPU D15:0 ↔ VME D15:0.
- d32_high_oe, d32_high_dir  out  1  CPU D31:16 ↔ VME D31:16.
- status_led  out  1  1 while a VME cycle is in ADDRESS or DATA.

## Operation
States: IDLE, ADDRESS, DATA, TERMINATE.
- **IDLE**
  - All outputs at their inactive values.
  - Start condition: request_vme_sync, bus_acquired_sync active, vme_dtack_sync and vme_berr_sync inactive, request_space != 11.
  - On start: latch write, size, AM and transfer width; assert addr_oe; go to ADDRESS.
  - Reserved space, or FC 000/011/100/111 (including IACK): go to TERMINATE with cpu_berr active and no VME strobes.
- **AM selection**, FC 001/010/101/110 → user data/user program/supervisor data/supervisor program.
  - A16: 29/29/2D/2D.
  - A24: 39/3A/3D/3E.
  - A32: 09/0A/0D/0E.
- **Transfer width**
  - D32 only when DATA_WIDTH==32, cpu_siz==00 and cpu_address==00: vme_lword active, vme_ds=00, d32_low and d32_high enabled, DSACK=00.
  - Otherwise, byte when cpu_siz==01 or cpu_address[0]==1: vme_ds = address[0] ? 10 : 01.
  - Otherwise word: vme_ds=00.
  - Byte and word use d16_cross and DSACK=01.
- **ADDRESS**
  - vme_as asserted on entry.
  - Setup counter counts SETUP_CYCLES clocks.
  - Exits to DATA when the count has expired and cpu_ds_sync is active.
  - On exit, enable the data transceivers with dir = write ? OUT(0) : IN(1).
- **DATA**
  - vme_ds asserted; timeout counter runs from 0.
  - Priority order: vme_berr_sync → cpu_berr; then vme_dtack_sync → cpu_dsack per width; then counter == TIMEOUT_CYCLES-1 → cpu_berr; then request_vme_sync inactive → cpu_berr.
  - Every exit goes to TERMINATE.
- **TERMINATE**
  - Hold the CPU termination.
  - On a bus-error exit, negate vme_ds and vme_as immediately; otherwise hold them.
  - Exit when cpu_ds_sync and request_vme_sync are both inactive. Exit clocks everything to inactive and returns to IDLE.

## Timing
- Reset, synchronous:
  - state IDLE, counters 0.
  - All `*_oe` 1; all `*_dir` 0.
  - vme_as, vme_lword, vme_write 1; vme_ds 11; vme_address_mod 3F.
  - cpu_dsack 11, cpu_berr 1, status_led 0.
- Reset mid-cycle drops every strobe and transceiver on the next edge.
- Latency:
  - start condition → addr_oe plus AM valid: 1 clock.
  - vme_as: 1 clock later.
  - vme_ds: SETUP_CYCLES clocks after vme_as, or later if the CPU DS is late.
  - vme_dtack_sync → cpu_dsack: 1 clock.
- The timeout fires exactly TIMEOUT_CYCLES clocks after DATA entry.
- Counters saturate and never wrap.
- A simultaneous DTACK and BERR is treated as BERR.
- A new cycle cannot start while the previous slave still drives DTACK or BERR.

## Structure
- Shared package `vme_pkg`:
  - state enum;
  - ACTIVE/INACTIVE and DIR_IN/DIR_OUT constants;
  - space encodings;
  - AM lookup function (space, fc).
- One sub-module, `vme_cycle_timer`: loadable saturating down-counter used for both setup and timeout, with a $clog2-sized width.

## Test plan
- A24 supervisor-data word read at address 0, DTACK after 5 clocks:
  - AM=3D, vme_ds=00 from 2 clocks after vme_as;
  - d16_cross_dir=1;
  - cpu_dsack=01 one clock after DTACK;
  - back in IDLE once the CPU DS releases.
- DATA_WIDTH=32, A32 long write at address 0 → AM=0D, vme_lword=0, d32_low/d32_high dir=0, cpu_dsack=00. The same transfer at address 2 → word, DSACK=01.
- A16 byte write at an odd address → AM=29 or 2D, vme_ds=10, DSACK=01.
- No DTACK, TIMEOUT_CYCLES=16 → cpu_berr exactly 16 clocks after DATA entry; VME strobes negate the same edge.
- FC=111 IACK request → cpu_berr and no vme_as assertion. A VME BERR coincident with DTACK → cpu_berr, cpu_dsack stays 11.
- Reset asserted mid-DATA → all outputs at reset values after one edge. The next request starts a fresh cycle.
